// File: rtl/fetch1_pc_gen.sv
// Fetch1: owns the fetch PC, issues one icache request per cycle and hands
// {pc, BTB prediction, ADEF} to Fetch2; redirects always override fetch.
//
// state     | meaning
// RUN       | normal fetch, one packet per cycle when icache and Fetch2 allow
// HOLD_EXCP | misaligned PC already reported as ADEF; idle until a redirect
module fetch1_pc_gen #(
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = 32'h1c00_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush_i,
  input  logic [PC_W-1:0] flush_target_i,
  input  logic            bp_redirect_i,
  input  logic [PC_W-1:0] bp_target_i,
  output logic [PC_W-1:0] btb_pc_o,
  input  logic            btb_hit_i,
  input  logic            btb_taken_i,
  input  logic [PC_W-1:0] btb_target_i,
  output logic            icache_req_o,
  output logic [PC_W-1:0] icache_addr_o,
  input  logic            icache_ready_i,
  input  logic            next_rdy_in_i,
  output logic            pass_valid_o,
  output logic [PC_W-1:0] pass_pc_o,
  output logic            pass_btb_taken_o,
  output logic [PC_W-1:0] pass_btb_target_o,
  output logic            excp_adef_o
);

  typedef enum logic {RUN, HOLD_EXCP} state_t;

  state_t          state;
  logic [PC_W-1:0] pc;
  logic            redirect;
  logic [PC_W-1:0] redir_tgt;
  logic            misal;
  logic            run;
  logic            fire;
  logic            taken;

  always_comb begin
    redirect  = flush_i | bp_redirect_i;
    redir_tgt = flush_i ? flush_target_i : bp_target_i;
    misal     = (pc[1:0] != 2'b00);
    // rst_n gates the launch so nothing leaves the stage while reset is held
    run       = rst_n & (state == RUN) & ~redirect & next_rdy_in_i;
    fire      = run & (misal | icache_ready_i);
    taken     = btb_hit_i & btb_taken_i & ~misal;
  end

  assign btb_pc_o          = pc;
  assign icache_addr_o     = pc;
  assign icache_req_o      = run & ~misal;
  assign pass_valid_o      = fire;
  assign pass_pc_o         = pc;
  assign pass_btb_taken_o  = taken;
  assign pass_btb_target_o = btb_target_i;
  assign excp_adef_o       = fire & misal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc    <= RESET_PC;
      state <= RUN;
    end else if (redirect) begin
      pc    <= redir_tgt;
      state <= RUN;
    end else if (fire && !misal) begin
      pc    <= taken ? btb_target_i : pc + PC_W'(4);
    end else if (fire && misal) begin
      state <= HOLD_EXCP;
    end
  end

endmodule

// File: tb/tb_fetch1_pc_gen.sv
// Bench for fetch1_pc_gen: directed cycles push expected packets into a queue;
// a negedge monitor pops and compares whenever pass_valid_o is seen.
module tb_fetch1_pc_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush_i, bp_redirect_i, btb_hit_i, btb_taken_i;
  logic        icache_ready_i, next_rdy_in_i;
  logic [31:0] flush_target_i, bp_target_i, btb_target_i;
  logic [31:0] btb_pc_o, icache_addr_o, pass_pc_o, pass_btb_target_o;
  logic        icache_req_o, pass_valid_o, pass_btb_taken_o, excp_adef_o;

  typedef struct packed {
    logic [31:0] pc;
    logic        tkn;
    logic [31:0] tgt;
    logic        adef;
  } pkt_t;

  pkt_t q[$];
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b1;

  always #5 clk = ~clk;

  fetch1_pc_gen dut (
    .clk(clk), .rst_n(rst_n),
    .flush_i(flush_i), .flush_target_i(flush_target_i),
    .bp_redirect_i(bp_redirect_i), .bp_target_i(bp_target_i),
    .btb_pc_o(btb_pc_o), .btb_hit_i(btb_hit_i), .btb_taken_i(btb_taken_i),
    .btb_target_i(btb_target_i),
    .icache_req_o(icache_req_o), .icache_addr_o(icache_addr_o),
    .icache_ready_i(icache_ready_i), .next_rdy_in_i(next_rdy_in_i),
    .pass_valid_o(pass_valid_o), .pass_pc_o(pass_pc_o),
    .pass_btb_taken_o(pass_btb_taken_o), .pass_btb_target_o(pass_btb_target_o),
    .excp_adef_o(excp_adef_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Monitor: every negedge either a packet is expected and seen, or neither.
  always @(negedge clk) begin
    pkt_t e;
    if (mon_en) begin
      if (pass_valid_o) begin
        if (q.size() == 0) begin
          chk("unexpected_packet", {31'd0, pass_valid_o}, 32'd0);
        end else begin
          e = q.pop_front();
          chk("pkt_pc", pass_pc_o, e.pc);
          chk("pkt_taken", {31'd0, pass_btb_taken_o}, {31'd0, e.tkn});
          chk("pkt_target", pass_btb_target_o, e.tgt);
          chk("pkt_adef", {31'd0, excp_adef_o}, {31'd0, e.adef});
        end
      end else if (q.size() != 0) begin
        e = q.pop_front();
        chk("missing_packet", {31'd0, pass_valid_o}, 32'd1);
      end else begin
        chk("idle_adef", {31'd0, excp_adef_o}, 32'd0);
      end
    end
  end

  // One cycle: drive inputs after the edge, queue any expected packet, check PC/req.
  task automatic cyc(input logic fl, input logic [31:0] ft,
                     input logic bp, input logic [31:0] bt,
                     input logic hit, input logic tk, input logic [31:0] tg,
                     input logic rdy, input logic nrdy,
                     input logic [31:0] epc, input logic ereq,
                     input logic ev, input logic etk, input logic eadef);
    pkt_t p;
    @(posedge clk);
    #1;
    flush_i = fl; flush_target_i = ft;
    bp_redirect_i = bp; bp_target_i = bt;
    btb_hit_i = hit; btb_taken_i = tk; btb_target_i = tg;
    icache_ready_i = rdy; next_rdy_in_i = nrdy;
    if (ev) begin
      p.pc = epc; p.tkn = etk; p.tgt = tg; p.adef = eadef;
      q.push_back(p);
    end
    #2;
    chk("btb_pc", btb_pc_o, epc);
    chk("icache_addr", icache_addr_o, epc);
    chk("icache_req", {31'd0, icache_req_o}, {31'd0, ereq});
  endtask

  initial begin
    rst_n = 1'b0;
    flush_i = 0; flush_target_i = 0; bp_redirect_i = 0; bp_target_i = 0;
    btb_hit_i = 0; btb_taken_i = 0; btb_target_i = 0;
    icache_ready_i = 1; next_rdy_in_i = 1;
    repeat (2) @(posedge clk);
    #3;
    chk("rst_valid", {31'd0, pass_valid_o}, 32'd0);
    chk("rst_req", {31'd0, icache_req_o}, 32'd0);
    chk("rst_pc", btb_pc_o, 32'h1c00_0000);
    next_rdy_in_i = 0;
    @(negedge clk);
    #1 rst_n = 1'b1;

    //   fl ft            bp bt            hit tk tg            rdy nrdy pc            req v  tk adef
    cyc(0, 0,            0, 0,            0, 0, 0,            1, 1, 32'h1c000000, 1, 1, 0, 0);
    cyc(0, 0,            0, 0,            0, 0, 0,            1, 1, 32'h1c000004, 1, 1, 0, 0);
    cyc(0, 0,            0, 0,            1, 1, 32'h1c000100, 1, 1, 32'h1c000008, 1, 1, 1, 0);
    cyc(0, 0,            0, 0,            0, 0, 0,            1, 1, 32'h1c000100, 1, 1, 0, 0);
    cyc(0, 0,            0, 0,            1, 0, 32'h1c000300, 1, 1, 32'h1c000104, 1, 1, 0, 0);
    cyc(0, 0,            0, 0,            0, 1, 32'h1c000400, 1, 1, 32'h1c000108, 1, 1, 0, 0);
    // icache stall three cycles, then accept
    for (int i = 0; i < 3; i++)
      cyc(0, 0,          0, 0,            0, 0, 0,            0, 1, 32'h1c00010c, 1, 0, 0, 0);
    cyc(0, 0,            0, 0,            0, 0, 0,            1, 1, 32'h1c00010c, 1, 1, 0, 0);
    // Fetch2 stall: no request at all
    for (int i = 0; i < 2; i++)
      cyc(0, 0,          0, 0,            0, 0, 0,            1, 0, 32'h1c000110, 0, 0, 0, 0);
    // flush + mispredict together while stalled: flush target wins
    cyc(1, 32'h1c008000, 1, 32'h1c000200, 0, 0, 0,            1, 0, 32'h1c000110, 0, 0, 0, 0);
    cyc(0, 0,            0, 0,            0, 0, 0,            1, 1, 32'h1c008000, 1, 1, 0, 0);
    // redirect in a would-be fire cycle, to a misaligned target
    cyc(0, 0,            1, 32'h1c000202, 0, 0, 0,            1, 1, 32'h1c008004, 0, 0, 0, 0);
    cyc(0, 0,            0, 0,            1, 1, 32'h1c000500, 0, 1, 32'h1c000202, 0, 1, 0, 1);
    for (int i = 0; i < 5; i++)
      cyc(0, 0,          0, 0,            0, 0, 0,            1, 1, 32'h1c000202, 0, 0, 0, 0);
    cyc(1, 32'h1c008000, 0, 0,            0, 0, 0,            1, 1, 32'h1c000202, 0, 0, 0, 0);
    cyc(0, 0,            0, 0,            0, 0, 0,            1, 1, 32'h1c008000, 1, 1, 0, 0);
    // misaligned redirect while Fetch2 stalled; ADEF only once it is ready
    cyc(0, 0,            1, 32'h1c000206, 0, 0, 0,            1, 0, 32'h1c008004, 0, 0, 0, 0);
    cyc(0, 0,            0, 0,            0, 0, 0,            1, 0, 32'h1c000206, 0, 0, 0, 0);
    cyc(0, 0,            0, 0,            0, 0, 0,            1, 1, 32'h1c000206, 0, 1, 0, 1);
    cyc(0, 0,            0, 0,            0, 0, 0,            1, 1, 32'h1c000206, 0, 0, 0, 0);

    // async reset while parked in HOLD_EXCP
    @(posedge clk);
    #1 rst_n = 1'b0;
    #2;
    chk("midrst_valid", {31'd0, pass_valid_o}, 32'd0);
    chk("midrst_req", {31'd0, icache_req_o}, 32'd0);
    chk("midrst_pc", btb_pc_o, 32'h1c00_0000);
    next_rdy_in_i = 0;
    @(negedge clk);
    #1 rst_n = 1'b1;

    cyc(0, 0,            0, 0,            0, 0, 0,            1, 1, 32'h1c000000, 1, 1, 0, 0);
    // PC wraps past the top of the address space
    cyc(0, 0,            1, 32'hfffffffc, 0, 0, 0,            1, 1, 32'h1c000004, 0, 0, 0, 0);
    cyc(0, 0,            0, 0,            0, 0, 0,            1, 1, 32'hfffffffc, 1, 1, 0, 0);
    cyc(0, 0,            0, 0,            0, 0, 0,            1, 1, 32'h00000000, 1, 1, 0, 0);
    cyc(1, 32'h1c000040, 0, 0,            0, 0, 0,            1, 1, 32'h00000004, 0, 0, 0, 0);
    cyc(0, 0,            0, 0,            0, 0, 0,            1, 1, 32'h1c000040, 1, 1, 0, 0);

    @(negedge clk);
    #1;
    mon_en = 1'b0;
    chk("queue_drained", q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
